// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder bit per clock, LSB
// first, with a registered carry between bits. Parallel operands in, parallel
// result out with a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the sub port (a - b).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             s_d;
    logic             c_d;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] sb_load;
    logic             c_load;

    // Full adder built from two chained half adders plus an OR for the carry.
    // Returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic h1_s, h1_c, h2_s, h2_c;
        h1_s = x ^ y;
        h1_c = x & y;
        h2_s = h1_s ^ ci;
        h2_c = h1_s & ci;
        return {h1_c | h2_c, h2_s};
    endfunction

    // One-bit datapath: current LSBs plus carry, and the result register shifted
    // right with the new sum bit entering at the MSB.
    always_comb begin
        {c_d, s_d} = full_add(sa_q[0], sb_q[0], c_q);
        r_d        = {s_d, r_q[WIDTH-1:1]};
    end

    // Operand B and initial carry as loaded on acceptance; subtraction is
    // a + ~b + 1, so it only changes what gets loaded, never the datapath.
    always_comb begin
        sb_load = b;
        c_load  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            sb_load = ~b;
            c_load  = 1'b1;
        end
`endif
    end

    // Control FSM with registered outputs; sum/cout only update on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            r_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= sb_load;
                        c_q     <= c_load;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    c_q   <= c_d;
                    r_q   <= r_d;
                    if (cnt_q == LAST_BIT) begin
                        // Counter parks at zero so it never exceeds WIDTH-1.
                        cnt_q   <= '0;
                        sum_q   <= r_d;
                        cout_q  <= c_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). A behavioural model derived
// from the timing rules (accept edge, result WIDTH edges later, one-cycle done)
// and plain integer arithmetic is compared against the DUT every cycle, with
// hand-computed literal checks on top. Honours SERIAL_ADDER_SUB_EN.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub   = 1'b0;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_since = -1;   // cycles since acceptance, -1 when idle
    bit           m_busy  = 1'b0;
    bit           m_done  = 1'b0;
    bit           m_cout  = 1'b0;
    logic [W-1:0] m_sum   = '0;
    logic [W-1:0] p_sum   = '0;
    bit           p_cout  = 1'b0;

    function automatic bit cur_sub();
`ifdef SERIAL_ADDER_SUB_EN
        return sub;
`else
        return 1'b0;
`endif
    endfunction

    // {cout, sum}: a+b, or a-b expressed as a + (2^W - b) whose top bit is "no borrow"
    function automatic logic [W:0] ref_calc(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
        logic [W:0] modulus;
        modulus = (W+1)'(1) << W;
        if (s) return {1'b0, x} + (modulus - {1'b0, y});
        return {1'b0, x} + {1'b0, y};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_since = -1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_since >= 0) begin
                m_since++;
                if (m_since == W) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_sum  = p_sum;
                    m_cout = p_cout;
                end else if (m_since == W + 1) begin
                    m_since = -1;
                end
            end else if (start) begin
                {p_cout, p_sum} = ref_calc(a, b, cur_sub());
                m_since = 0;
                m_busy  = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("cyc_busy", 32'(busy), 32'(m_busy));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_sum",  32'(sum),  32'(m_sum));
        chk("cyc_cout", 32'(cout), 32'(m_cout));
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) chk("idle_timeout", 32'(busy | done), 32'd0);
    endtask

    // Issues one request (sub already set by caller) and checks literal results.
    task automatic run_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] esum, input bit ecout);
        int lat;
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk({nm, "_lat"},  32'(lat),  32'(W));
        chk({nm, "_sum"},  32'(sum),  32'(esum));
        chk({nm, "_cout"}, 32'(cout), 32'(ecout));
        @(negedge clk);
        chk({nm, "_done_width"}, 32'(done), 32'd0);
        wait_idle();
    endtask

    task automatic do_add(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] esum, input bit ecout);
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        run_op(nm, ia, ib, esum, ecout);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int last;
        int ndone;

        // reset
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);

        do_add("add_5a_3c", 8'h5A, 8'h3C, 8'h96, 1'b0);
        do_add("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_sum",  32'(sum),  32'h00);
            chk("hold_cout", 32'(cout), 32'd1);
        end

        // Second request during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'hF0;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("ignored_sum",  32'(sum),  32'h02);
        chk("ignored_cout", 32'(cout), 32'd0);
        wait_idle();
        do_add("add_f0_0f", 8'hF0, 8'h0F, 8'hFF, 1'b0);

        // start held high: accepted every W+2 cycles, one-cycle done pulses.
        @(negedge clk);
        start = 1'b1; a = 8'h21; b = 8'h43;
        last  = -1;
        ndone = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0) chk("held_gap", 32'(i - last), 32'(W + 2));
                last = i;
                ndone++;
            end
        end
        start = 1'b0;
        chk("held_count", 32'(ndone), 32'd4);
        chk("held_sum",   32'(sum),   32'h64);
        wait_idle();

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h44;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum",  32'(sum),  32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        do_add("add_10_20", 8'h10, 8'h20, 8'h30, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op("sub_10_01", 8'h10, 8'h01, 8'h0F, 1'b1);
        sub = 1'b1;
        run_op("sub_00_01", 8'h00, 8'h01, 8'hFF, 1'b0);
`endif

        // Randomized traffic, checked cycle by cycle by the model.
        for (int k = 0; k < 150; k++) begin
            int gap;
            int hold;
            gap  = $urandom_range(0, 3);
            hold = $urandom_range(1, W - 2);
            repeat (gap) @(negedge clk);
            @(negedge clk);
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub   = 1'($urandom_range(0, 1));
`endif
            repeat (hold) @(negedge clk);
            start = 1'b0;
            wait_done(lat);
            wait_idle();
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder: one full-adder bit per clock, LSB first, with a registered carry between bits. The per-bit sum/carry equations are the half-adder pair (sum = a^b, carry = a&b) chained twice, plus an OR for the carry. The block takes parallel operands, walks them through this one-bit datapath, and returns a parallel result with a done pulse. It sits directly downstream of the half-adder stage as its first sequential consumer.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2 to 32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- sub  in  1  present only with SERIAL_ADDER_SUB_EN; captured with a and b.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; sum and cout are valid and new.
- sum  out  WIDTH  result; holds its value until the next completion.
- cout  out  1  carry out of bit WIDTH-1; holds like sum.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, sum=0, cout=0. Internal shift registers, carry and counter also reset to 0.
- IDLE with start=1:
  - load shift regs SA=a and SB=b.
  - set carry c=0, set counter cnt=0.
  - go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, every cycle:
  - compute s = SA[0]^SB[0]^c and c_next = (SA[0]&SB[0]) | (c&(SA[0]^SB[0])).
  - shift s into the MSB of the internal result register R (right shift).
  - shift SA and SB right by one; c <= c_next; cnt <= cnt+1.
- RUN on the cycle where cnt==WIDTH-1: perform the last bit, then go to DONE.
  - Also load sum from the final R including this bit, and load cout from c_next.
- DONE: assert done for exactly one cycle, then go to IDLE.
- start is ignored in RUN and in DONE. It is not queued.
  - A request held high through DONE is accepted on the first IDLE edge.
- Arithmetic is modulo 2^WIDTH. Carry beyond cout is discarded.
- Width of cnt is ceil(log2(WIDTH)). It never exceeds WIDTH-1.
- sum and cout change only on the DONE-entry edge. They never show partial results.
- Reset asserted mid-operation:
  - the FSM returns to IDLE immediately and asynchronously.
  - all outputs go to their reset values and the operation is lost.

## Timing
- Edge 0 samples start=1 in IDLE. busy=1 from edge 0 to edge WIDTH.
- Bits 0..WIDTH-1 are processed at edges 1..WIDTH.
- After edge WIDTH: done=1, busy=0, sum and cout are valid.
- After edge WIDTH+1: done=0, state is IDLE.
- Latency from accepting edge to done is WIDTH cycles.
- Minimum spacing between accepted starts is WIDTH+2 cycles.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - the sub port exists.
  - when sub=1 at acceptance, SB loads ~b and c loads 1, giving sum = a-b.
  - cout=1 means no borrow, cout=0 means borrow.
- SERIAL_ADDER_SUB_EN undefined:
  - the sub port is absent.
  - the block only adds. Behaviour is identical to sub=0.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start pulse -> done exactly 8 cycles after acceptance, sum=0x96, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1. sum stays 0x00 through the following IDLE cycles.
- Start a=0x01, b=0x01; pulse start again at cycle 3 with a=0xF0 -> second request ignored, sum=0x02. Next start with a=0xF0, b=0x0F is accepted, giving sum=0xFF, cout=0.
- Hold start high continuously -> accepted every 10 cycles (WIDTH+2); done pulses one cycle wide each time.
- Assert rst_n low at cycle 4 of RUN -> busy, done, sum and cout are 0 immediately. After release, a fresh add of 0x10+0x20 gives sum=0x30.
- With SERIAL_ADDER_SUB_EN: 0x10-0x01 -> sum=0x0F, cout=1; 0x00-0x01 -> sum=0xFF, cout=0.
